// File: rtl/axi_pkg.sv
// Shared constants and types for the two-master AXI read arbiter.
//   ID_W/IDS_W/ADDR_W/DATA_W/LEN_W : default bus field widths
//   state_e                        : arbiter FSM states
//   INCR / OKAY                    : burst type and response encodings
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int IDS_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] INCR = 2'd1;
  localparam logic [1:0] OKAY = 2'd0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
//   req : request vector, bit x set when master x wants the bus
//   p   : priority pointer, master index favoured when both request
//   gnt : index of the chosen master (holds p when nobody requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       p,
  output logic       gnt
);

  always_comb begin
    gnt = p;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = p;
    endcase
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read slave port (AR + R) between two masters:
// M0 = instruction fetch, M1 = data load. One complete burst is granted at a
// time, round-robin. The slave-side ARID carries the master index above the
// master's own ID; R beats are routed only to the currently granted master.
// Ports:
//   ACLK, ARESETn                  : clock, async active-low reset
//   AR*_M0/AR*_M1, ARREADY_M{0,1}  : per-master read address channels
//   R*_M0/R*_M1, RREADY_M{0,1}     : per-master read data channels
//   AR*_S, ARREADY_S               : shared slave read address channel
//   R*_S, RREADY_S                 : shared slave read data channel
module axi_read_arbiter #(
  parameter int ID_W   = axi_pkg::ID_W,
  parameter int IDS_W  = axi_pkg::IDS_W,
  parameter int ADDR_W = axi_pkg::ADDR_W,
  parameter int DATA_W = axi_pkg::DATA_W,
  parameter int LEN_W  = axi_pkg::LEN_W
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [LEN_W-1:0]  ARLEN_M0,
  input  logic [2:0]        ARSIZE_M0,
  input  logic [1:0]        ARBURST_M0,
  input  logic              ARVALID_M0,
  output logic              ARREADY_M0,
  output logic [ID_W-1:0]   RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [LEN_W-1:0]  ARLEN_M1,
  input  logic [2:0]        ARSIZE_M1,
  input  logic [1:0]        ARBURST_M1,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M1,
  output logic [ID_W-1:0]   RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  output logic [IDS_W-1:0]  ARID_S,
  output logic [ADDR_W-1:0] ARADDR_S,
  output logic [LEN_W-1:0]  ARLEN_S,
  output logic [2:0]        ARSIZE_S,
  output logic [1:0]        ARBURST_S,
  output logic              ARVALID_S,
  input  logic              ARREADY_S,
  input  logic [IDS_W-1:0]  RID_S,
  input  logic [DATA_W-1:0] RDATA_S,
  input  logic [1:0]        RRESP_S,
  input  logic              RLAST_S,
  input  logic              RVALID_S,
  output logic              RREADY_S
);

  import axi_pkg::*;

  state_e state_q, state_d;
  logic   g_q, g_d;
  logic   p_q, p_d;
  logic   pick;

  logic              arvalid_g;
  logic              rready_g;
  logic [ID_W-1:0]   arid_g;
  logic [ADDR_W-1:0] araddr_g;
  logic [LEN_W-1:0]  arlen_g;
  logic [2:0]        arsize_g;
  logic [1:0]        arburst_g;

  // Only one transaction is ever outstanding, so the returned tag bits are
  // not needed for routing.
  logic unused_rid_tag;
  assign unused_rid_tag = ^RID_S[IDS_W-1:ID_W];

  rr_arb2 u_rr_arb2 (
    .req ({ARVALID_M1, ARVALID_M0}),
    .p   (p_q),
    .gnt (pick)
  );

  assign arvalid_g = g_q ? ARVALID_M1 : ARVALID_M0;
  assign rready_g  = g_q ? RREADY_M1  : RREADY_M0;
  assign arid_g    = g_q ? ARID_M1    : ARID_M0;
  assign araddr_g  = g_q ? ARADDR_M1  : ARADDR_M0;
  assign arlen_g   = g_q ? ARLEN_M1   : ARLEN_M0;
  assign arsize_g  = g_q ? ARSIZE_M1  : ARSIZE_M0;
  assign arburst_g = g_q ? ARBURST_M1 : ARBURST_M0;

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          g_d     = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // A master dropping ARVALID early keeps its grant; no re-arbitration.
        if (arvalid_g && ARREADY_S) state_d = DATA;
      end
      DATA: begin
        if (RVALID_S && rready_g && RLAST_S) begin
          state_d = IDLE;
          p_d     = ~g_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: everything idles at zero outside the owning phase
  always_comb begin
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    ARVALID_S  = 1'b0;
    RREADY_S   = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    RVALID_M1  = 1'b0;
    case (state_q)
      ADDR: begin
        ARVALID_S  = arvalid_g;
        // Master index sits directly above the master's own ID bits.
        ARID_S     = (IDS_W'(g_q) << ID_W) | IDS_W'(arid_g);
        ARADDR_S   = araddr_g;
        ARLEN_S    = arlen_g;
        ARSIZE_S   = arsize_g;
        ARBURST_S  = arburst_g;
        ARREADY_M0 = ~g_q & ARREADY_S;
        ARREADY_M1 =  g_q & ARREADY_S;
      end
      DATA: begin
        RREADY_S = rready_g;
        if (g_q) begin
          RID_M1    = RID_S[ID_W-1:0];
          RDATA_M1  = RDATA_S;
          RRESP_M1  = RRESP_S;
          RLAST_M1  = RLAST_S;
          RVALID_M1 = RVALID_S;
        end else begin
          RID_M0    = RID_S[ID_W-1:0];
          RDATA_M0  = RDATA_S;
          RRESP_M0  = RRESP_S;
          RLAST_M0  = RLAST_S;
          RVALID_M0 = RVALID_S;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI read slave port (AR + R channels) between two read masters: M0 = instruction fetch, M1 = data load.
- Sits between the CPU-side master wrappers and the slave read port of the bus fabric.
- Grants one complete burst at a time, round-robin between masters.
- Tags the slave-side ID with the master index and routes R beats back only to the granted master.

Parameters:
ID_W, 4, master-side ARID/RID width
IDS_W, 8, slave-side ID width; upper IDS_W-ID_W bits carry master tag
ADDR_W, 32, address width
DATA_W, 32, data width
LEN_W, 4, ARLEN width

Ports:
ACLK  in  1  clock
ARESETn  in  1  async active-low reset
ARID_M{0,1}  in  ID_W  per-master AR id
ARADDR_M{0,1}  in  ADDR_W  per-master AR address
ARLEN_M{0,1}  in  LEN_W  per-master burst length-1
ARSIZE_M{0,1}  in  3  per-master beat size
ARBURST_M{0,1}  in  2  per-master burst type
ARVALID_M{0,1}  in  1  per-master AR valid
ARREADY_M{0,1}  out  1  per-master AR ready
RID_M{0,1}  out  ID_W  per-master R id
RDATA_M{0,1}  out  DATA_W  per-master R data
RRESP_M{0,1}  out  2  per-master R response
RLAST_M{0,1}  out  1  per-master last beat
RVALID_M{0,1}  out  1  per-master R valid
RREADY_M{0,1}  in  1  per-master R ready
ARID_S  out  IDS_W  {tag, ARID_Mg}; tag=0 for M0, 1 for M1
ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  out  as master  granted master's fields
ARVALID_S  out  1  slave AR valid
ARREADY_S  in  1  slave AR ready
RID_S  in  IDS_W  slave R id
RDATA_S  in  DATA_W  slave R data
RRESP_S  in  2  slave R response
RLAST_S  in  1  slave last beat
RVALID_S  in  1  slave R valid
RREADY_S  out  1  slave R ready

Behaviour:
- FSM with states IDLE, ADDR, DATA; registered grant g (1 bit) and priority pointer p (1 bit).
- IDLE:
  - Drives ARVALID_S=0, RREADY_S=0; all ARREADY_M/RVALID_M = 0.
  - If exactly one ARVALID_Mx: g<=x. If both: g<=p.
  - Any request -> ADDR on the next edge (one-cycle arbitration latency).
- ADDR:
  - ARVALID_S=ARVALID_Mg; AR fields muxed from master g.
  - ARREADY_Mg=ARREADY_S; the other master's ARREADY=0.
  - On ARVALID_S & ARREADY_S -> DATA.
  - If ARVALID_Mg drops before handshake (protocol violation), stay in ADDR; no regrant.
- DATA:
  - RVALID_Mg=RVALID_S; RREADY_S=RREADY_Mg; RID_Mg=RID_S[ID_W-1:0]; RDATA/RRESP/RLAST forwarded.
  - The non-granted master sees RVALID=0 and RDATA=0.
  - On RVALID_S & RREADY_S & RLAST_S -> IDLE and p<=~g.
  - Non-last beats stay in DATA, giving multi-beat bursts.
  - RID_S tag is not used for routing (single outstanding transaction); a mismatch is ignored.
- Starvation: with both masters requesting continuously, grants alternate M0, M1, M0, ...
- A new request can be granted in the IDLE cycle immediately after the RLAST handshake (minimum 1 idle cycle between bursts).
- Simultaneous ARVALID rise with RLAST handshake: the request is seen in the following IDLE cycle.
- Reset values (async, any state): state=IDLE, g=0, p=0 (M0 first); all outputs 0.
- Reset mid-burst abandons the transaction with no response to the master.
- Outputs are combinational from state/g and the muxed inputs; there are no combinational ARVALID->ARREADY paths except through the slave.

Decomposition:
- Shared package axi_pkg holds:
  - the ID_W/IDS_W/ADDR_W/DATA_W/LEN_W constants;
  - the state enum {IDLE, ADDR, DATA};
  - burst type constants (INCR=2'd1) and response constants (OKAY=2'd0).
- One sub-module is natural: rr_arb2, the 2-way round-robin pick (req[1:0], p -> gnt index).

Test Plan:
- Single request: ARVALID_M0=1, ARADDR_M0=0x0000_0100, ARID=4'h3, ARLEN=0; slave ARREADY after 2 cycles, RDATA=0xDEAD_BEEF with RLAST. Expect ARID_S=8'h03, RVALID_M0 with data 0xDEAD_BEEF and RID_M0=4'h3; M1 sees RVALID=0; 1 idle cycle after reset before ARVALID_S.
- Contention: both masters request from reset. Expect grant order M0, M1, M0; ARID_S tags 8'h0x, 8'h1x.
- Burst: M1 ARLEN=3, slave returns 4 beats with RREADY_M1 toggling 1,0,1. Expect 4 handshakes routed to M1 and the FSM returning to IDLE only after the RLAST beat.
- Backpressure: slave holds ARREADY_S=0 for 10 cycles. Expect AR fields to stay stable and ARREADY_M0=0 throughout.
- Reset mid-DATA: assert ARESETn=0 after the 2nd beat. Expect all outputs 0 immediately and the next grant going to M0.
- Back-to-back: M0 requests again in the cycle after its RLAST while M1 is waiting. Expect M1 granted (p updated).
